mtsp_ew_arbiter: RTL and testbench

Parametrised external-write arbiter for the MTSP core's GPR file. It is the next generation of the single-path EW1 merge stage. Up to CH_COUNT producers (local memory block, scratch counters, pack/unpack, future units) each post masked 4-lane writes into a private FIFO. A fixed-priority or round-robin arbiter then drains the FIFOs into one registered GPR write port per cycle. Unlike the previous stage, simultaneous writers are never silently lost: they are queued and back-pressured.

---
 rtl/mtsp_ew_arbiter.sv | 143 ++++++++++++++
 tb/tb_mtsp_ew_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtsp_ew_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mtsp_ew_arbiter
// Purpose  : External-write arbiter for the MTSP GPR file. Each producer
//            channel posts masked 4-lane writes into a private FIFO; a
//            fixed-priority or round-robin arbiter drains one entry per cycle
//            onto a registered GPR write port.
// Revision : 1.0 - initial release
// ============================================================================
module mtsp_ew_arbiter #(
  parameter int CH_COUNT   = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int LANE_WIDTH = 32,
  parameter int ARB_MODE   = 0
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [CH_COUNT-1:0]              CH_nEN,
  input  logic [4*CH_COUNT-1:0]            CH_MASK,
  input  logic [ADDR_WIDTH*CH_COUNT-1:0]   CH_ADDR,
  input  logic [4*LANE_WIDTH*CH_COUNT-1:0] CH_DATA,
  output logic [CH_COUNT-1:0]              CH_FULL,
  output logic                             EW_nEN,
  output logic [3:0]                       EW_MASK,
  output logic [ADDR_WIDTH-1:0]            EW_ADDR,
  output logic [4*LANE_WIDTH-1:0]          EW_DATA,
  output logic                             OVERFLOW
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int IDX_W  = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;
  localparam int DATA_W = 4 * LANE_WIDTH;
  localparam int ENT_W  = 4 + ADDR_WIDTH + DATA_W;

  logic [CH_COUNT-1:0] push;
  logic [CH_COUNT-1:0] pop;
  logic [CH_COUNT-1:0] drop;
  logic [CH_COUNT-1:0] nonempty;
  logic [ENT_W-1:0]    head [CH_COUNT];

  logic                grant_valid;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    last_grant;
  logic [ENT_W-1:0]    grant_entry;

  for (genvar c = 0; c < CH_COUNT; c++) begin : g_ch
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             full_r;
    logic [3:0]       mask;
    logic             req_valid;

    // A request with every lane masked writes nothing, so it is not a request.
    assign mask        = CH_MASK[c*4 +: 4];
    assign req_valid   = !CH_nEN[c] && (mask != 4'b1111);
    // Full is judged on the registered flag, so a same-cycle pop cannot rescue a push.
    assign push[c]     = req_valid && !full_r;
    assign drop[c]     = req_valid && full_r;
    assign pop[c]      = grant_valid && (grant_idx == IDX_W'(c));
    assign nonempty[c] = (count != '0);
    assign head[c]     = mem[rd_ptr];
    assign CH_FULL[c]  = full_r;

    // Occupancy after this edge's push and pop.
    always_comb begin
      count_next = count;
      case ({push[c], pop[c]})
        2'b10:   count_next = count + CNT_W'(1);
        2'b01:   count_next = count - CNT_W'(1);
        default: count_next = count;
      endcase
    end

    // Pointer, count and full-flag registers for this channel.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        full_r <= 1'b0;
      end else begin
        if (push[c]) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop[c])  rd_ptr <= rd_ptr + PTR_W'(1);
        count  <= count_next;
        full_r <= (count_next == CNT_W'(FIFO_DEPTH));
      end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge CLK) begin
      if (push[c]) begin
        mem[wr_ptr] <= {mask, CH_ADDR[c*ADDR_WIDTH +: ADDR_WIDTH],
                        CH_DATA[c*DATA_W +: DATA_W]};
      end
    end
  end

  // Pick one non-empty channel: lowest index, or rotating from last_grant+1.
  always_comb begin
    int cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < CH_COUNT; i++) begin
      cand = (ARB_MODE == 1) ? ((int'(last_grant) + 1 + i) % CH_COUNT) : i;
      if (!grant_valid && nonempty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  assign grant_entry = head[grant_idx];

  // Registered GPR write port, rotation pointer and sticky overflow flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      EW_nEN     <= 1'b1;
      EW_MASK    <= 4'b1111;
      EW_ADDR    <= '0;
      EW_DATA    <= '0;
      OVERFLOW   <= 1'b0;
      last_grant <= IDX_W'(CH_COUNT - 1);
    end else begin
      OVERFLOW <= OVERFLOW | (|drop);
      if (grant_valid) begin
        EW_nEN                      <= 1'b0;
        {EW_MASK, EW_ADDR, EW_DATA} <= grant_entry;
        last_grant                  <= grant_idx;
      end else begin
        EW_nEN  <= 1'b1;
        EW_MASK <= 4'b1111;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mtsp_ew_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mtsp_ew_arbiter
// Purpose  : Self-checking bench for mtsp_ew_arbiter. Two instances (fixed
//            priority and round-robin) share the same producer inputs and are
//            compared every cycle against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mtsp_ew_arbiter;

  localparam int N  = 3;
  localparam int D  = 4;
  localparam int AW = 6;
  localparam int LW = 32;

  typedef struct packed {
    logic [3:0]      m;
    logic [AW-1:0]   a;
    logic [4*LW-1:0] d;
  } ent_t;

  logic              CLK;
  logic              RST;
  logic [N-1:0]      ch_nen;
  logic [4*N-1:0]    ch_mask;
  logic [AW*N-1:0]   ch_addr;
  logic [4*LW*N-1:0] ch_data;

  logic [N-1:0]      full0, full1;
  logic              nen0, nen1;
  logic [3:0]        mask0, mask1;
  logic [AW-1:0]     addr0, addr1;
  logic [4*LW-1:0]   data0, data1;
  logic              ovf0, ovf1;

  mtsp_ew_arbiter #(.CH_COUNT(N), .FIFO_DEPTH(D), .ADDR_WIDTH(AW),
                    .LANE_WIDTH(LW), .ARB_MODE(0)) dut_fixed (
    .CLK(CLK), .RST(RST), .CH_nEN(ch_nen), .CH_MASK(ch_mask),
    .CH_ADDR(ch_addr), .CH_DATA(ch_data), .CH_FULL(full0),
    .EW_nEN(nen0), .EW_MASK(mask0), .EW_ADDR(addr0), .EW_DATA(data0),
    .OVERFLOW(ovf0));

  mtsp_ew_arbiter #(.CH_COUNT(N), .FIFO_DEPTH(D), .ADDR_WIDTH(AW),
                    .LANE_WIDTH(LW), .ARB_MODE(1)) dut_rr (
    .CLK(CLK), .RST(RST), .CH_nEN(ch_nen), .CH_MASK(ch_mask),
    .CH_ADDR(ch_addr), .CH_DATA(ch_data), .CH_FULL(full1),
    .EW_nEN(nen1), .EW_MASK(mask1), .EW_ADDR(addr1), .EW_DATA(data1),
    .OVERFLOW(ovf1));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model state, one set per arbitration mode (index = mode).
  ent_t            q [2*N][$];
  int              lastg     [2];
  logic            exp_nen   [2];
  logic [3:0]      exp_mask  [2];
  logic [AW-1:0]   exp_addr  [2];
  logic [4*LW-1:0] exp_data  [2];
  logic            exp_ovf   [2];
  logic [N-1:0]    exp_full  [2];

  int nchk  = 0;
  int npass = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2*N; i++) q[i].delete();
    for (int md = 0; md < 2; md++) begin
      lastg[md]    = N - 1;
      exp_nen[md]  = 1'b1;
      exp_mask[md] = 4'b1111;
      exp_addr[md] = '0;
      exp_data[md] = '0;
      exp_ovf[md]  = 1'b0;
      exp_full[md] = '0;
    end
  endtask

  // One clock edge of the behavioural model for a given mode.
  task automatic model_step(input int md);
    logic [N-1:0] full_pre;
    int   g;
    int   ch;
    ent_t e;
    for (int c = 0; c < N; c++) full_pre[c] = (q[md*N+c].size() == D);
    g = -1;
    for (int i = 0; i < N; i++) begin
      ch = (md == 1) ? (lastg[md] + 1 + i) % N : i;
      if (g < 0 && q[md*N+ch].size() > 0) g = ch;
    end
    if (g >= 0) begin
      e = q[md*N+g].pop_front();
      exp_nen[md]  = 1'b0;
      exp_mask[md] = e.m;
      exp_addr[md] = e.a;
      exp_data[md] = e.d;
      lastg[md]    = g;
    end else begin
      exp_nen[md]  = 1'b1;
      exp_mask[md] = 4'b1111;
    end
    for (int c = 0; c < N; c++) begin
      if (!ch_nen[c] && ch_mask[c*4 +: 4] != 4'b1111) begin
        if (full_pre[c]) exp_ovf[md] = 1'b1;
        else q[md*N+c].push_back({ch_mask[c*4 +: 4], ch_addr[c*AW +: AW],
                                  ch_data[c*4*LW +: 4*LW]});
      end
    end
    for (int c = 0; c < N; c++) exp_full[md][c] = (q[md*N+c].size() == D);
  endtask

  task automatic compare_all();
    chk("fx_nen",  {127'd0, nen0},  {127'd0, exp_nen[0]});
    chk("fx_mask", {124'd0, mask0}, {124'd0, exp_mask[0]});
    chk("fx_addr", {122'd0, addr0}, {122'd0, exp_addr[0]});
    chk("fx_data", data0, exp_data[0]);
    chk("fx_full", {125'd0, full0}, {125'd0, exp_full[0]});
    chk("fx_ovf",  {127'd0, ovf0},  {127'd0, exp_ovf[0]});
    chk("rr_nen",  {127'd0, nen1},  {127'd0, exp_nen[1]});
    chk("rr_mask", {124'd0, mask1}, {124'd0, exp_mask[1]});
    chk("rr_addr", {122'd0, addr1}, {122'd0, exp_addr[1]});
    chk("rr_data", data1, exp_data[1]);
    chk("rr_full", {125'd0, full1}, {125'd0, exp_full[1]});
    chk("rr_ovf",  {127'd0, ovf1},  {127'd0, exp_ovf[1]});
  endtask

  // Advance one edge, update the model, compare, and return at the falling edge.
  task automatic tick();
    @(posedge CLK);
    if (RST) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    #1;
    compare_all();
    @(negedge CLK);
  endtask

  task automatic idle_all();
    ch_nen  = '1;
    ch_mask = '0;
    ch_addr = '0;
    ch_data = '0;
  endtask

  task automatic set_ch(input int c, input logic [3:0] m, input logic [AW-1:0] a,
                        input logic [4*LW-1:0] d);
    ch_nen[c]              = 1'b0;
    ch_mask[c*4 +: 4]      = m;
    ch_addr[c*AW +: AW]    = a;
    ch_data[c*4*LW +: 4*LW] = d;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle_all();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    idle_all();
    model_reset();
    #2;
    compare_all();
    @(negedge CLK);
    RST = 1'b0;

    // Single write: output exactly two edges after the request is presented.
    set_ch(1, 4'b0010, 6'd5, {32'd4, 32'd3, 32'd2, 32'd1});
    tick();
    idle_all();
    chk("single_early", {127'd0, nen0}, 128'd1);
    tick();
    chk("single_nen",  {127'd0, nen0}, 128'd0);
    chk("single_mask", {124'd0, mask0}, 128'b0010);
    chk("single_addr", {122'd0, addr0}, 128'd5);
    chk("single_data", data0, {32'd4, 32'd3, 32'd2, 32'd1});
    tick();
    chk("single_after", {127'd0, nen0}, 128'd1);

    // Fixed-priority collision: addresses drain as 1,2,3.
    do_reset();
    for (int c = 0; c < N; c++) set_ch(c, 4'b0000, 6'(c + 1), 128'(c + 100));
    tick();
    idle_all();
    for (int k = 0; k < N; k++) begin
      tick();
      chk("coll_addr", {122'd0, addr0}, 128'(k + 1));
      chk("coll_nen", {127'd0, nen0}, 128'd0);
    end
    tick();
    chk("coll_ovf", {127'd0, ovf0}, 128'd0);

    // Round-robin: three pushes per channel give grants 0,1,2 repeated.
    do_reset();
    for (int t = 0; t < 11; t++) begin
      idle_all();
      if (t < 3) for (int c = 0; c < N; c++) set_ch(c, 4'b0000, 6'(c*8 + t), 128'(t));
      tick();
      if (t >= 1 && t <= 9) begin
        chk("rr_order", {125'd0, addr1[5:3]}, 128'((t - 1) % 3));
        chk("rr_valid", {127'd0, nen1}, 128'd0);
      end
    end
    idle_all();

    // Full and overflow on the fixed-priority instance.
    do_reset();
    for (int t = 0; t < 5; t++) begin
      idle_all();
      set_ch(0, 4'b0000, 6'(16 + t), 128'(t));
      set_ch(2, 4'b0000, 6'(32 + t), 128'(1000 + t));
      tick();
      if (t == 3) chk("full_after4", {127'd0, full0[2]}, 128'd1);
      if (t == 4) chk("ovf_set", {127'd0, ovf0}, 128'd1);
    end
    idle_all();
    tick();
    chk("drain_ch0", {122'd0, addr0}, 128'd20);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("drain_ch2", {122'd0, addr0}, 128'(32 + k));
      chk("ovf_sticky", {127'd0, ovf0}, 128'd1);
    end

    // All-masked requests: no write, no overflow.
    do_reset();
    for (int t = 0; t < 3; t++) begin
      idle_all();
      set_ch(1, 4'b1111, 6'd9, 128'hABCD);
      tick();
      chk("masked_nen", {127'd0, nen0}, 128'd1);
      chk("masked_ovf", {127'd0, ovf0}, 128'd0);
    end
    idle_all();

    // Asynchronous reset with entries still queued.
    do_reset();
    for (int c = 0; c < N; c++) set_ch(c, 4'b0000, 6'(c + 40), 128'(c + 7));
    tick();
    idle_all();
    set_ch(0, 4'b0001, 6'd50, 128'd77);
    set_ch(1, 4'b0001, 6'd51, 128'd78);
    tick();
    idle_all();
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    chk("arst_nen",  {127'd0, nen0}, 128'd1);
    chk("arst_mask", {124'd0, mask0}, 128'b1111);
    chk("arst_addr", {122'd0, addr0}, 128'd0);
    chk("arst_data", data0, 128'd0);
    chk("arst_full", {125'd0, full0}, 128'd0);
    compare_all();
    tick();
    RST = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("arst_quiet", {127'd0, nen0 & nen1}, 128'd1);
    end

    // Randomised traffic against the model, with one reset in the middle.
    do_reset();
    for (int t = 0; t < 400; t++) begin
      idle_all();
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(9) < 5) begin
          set_ch(c, ($urandom_range(7) == 0) ? 4'b1111 : 4'($urandom),
                 6'($urandom), {$urandom, $urandom, $urandom, $urandom});
        end
      end
      if (t == 200) RST = 1'b1;
      tick();
      RST = 1'b0;
    end
    idle_all();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
`default_nettype wire
